// File: rtl/histogram_pkg.sv
// Shared types and constants for the histogram RAM controller and its RAM.
package histogram_pkg;

  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ACCUM   = 2'd1,
    DRAIN   = 2'd2,
    READOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_CLEAR   = 2'd1,
    CMD_READOUT = 2'd2
  } cmd_e;

endpackage

// File: rtl/histogram_ram.sv
// Simple dual-port histogram RAM: one write port, one read port with a LATENCY-deep read pipeline.
// Storage and read pipeline are intentionally not reset.
module histogram_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r  [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] pipe_r [0:LATENCY-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: a read-first access followed by LATENCY-1 delay stages
  always_ff @(posedge clk) begin
    pipe_r[0] <= mem_r[raddr];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign rdata = pipe_r[LATENCY-1];

endmodule

// File: rtl/histogram_ram_controller.sv
// Histogram RAM sequencer: clear, read-modify-write accumulation and valid/ready readout.
// Define HISTOGRAM_SATURATE_EN to clamp bin counters instead of letting them wrap.
module histogram_ram_controller
  import histogram_pkg::*;
#(
  parameter int BIN_WIDTH    = 16,
  parameter int CNT_IN_WIDTH = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vd,
  input  logic [BIN_WIDTH-1:0]      in_bin,
  input  logic [CNT_IN_WIDTH-1:0]   in_cnt,
  input  logic                      cmd_clear,
  input  logic                      cmd_readout,
  output logic                      busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [BIN_WIDTH-1:0]      rd_bin,
  output logic [COUNT_WIDTH-1:0]    rd_data,
  output logic                      rd_last
);

  localparam int DRAIN_WIDTH = $clog2(RAM_LATENCY + 1) + 1;
  localparam logic [BIN_WIDTH-1:0]      BIN_ZERO   = {BIN_WIDTH{1'b0}};
  localparam logic [BIN_WIDTH-1:0]      BIN_ONE    = BIN_WIDTH'(1);
  localparam logic [BIN_WIDTH-1:0]      LAST_BIN   = {BIN_WIDTH{1'b1}};
  localparam logic [DRAIN_WIDTH-1:0]    DRAIN_ZERO = {DRAIN_WIDTH{1'b0}};
  localparam logic [DRAIN_WIDTH-1:0]    DRAIN_ONE  = DRAIN_WIDTH'(1);
  localparam logic [DRAIN_WIDTH-1:0]    DRAIN_LAST = DRAIN_WIDTH'(RAM_LATENCY);
  localparam logic [COUNT_WIDTH-1:0]    COUNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ZERO  = {DROP_CNT_WIDTH{1'b0}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE   = DROP_CNT_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = {DROP_CNT_WIDTH{1'b1}};
`ifdef HISTOGRAM_SATURATE_EN
  localparam logic [COUNT_WIDTH-1:0]    COUNT_MAX  = {COUNT_WIDTH{1'b1}};
`endif

  state_e                   state_r, next_s;
  cmd_e                     cmd_r;
  logic [BIN_WIDTH-1:0]     clr_addr_r, ro_addr_r;
  logic [DRAIN_WIDTH-1:0]   drain_cnt_r;
  logic                     ro_pend_r, busy_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

  // One tag pipeline serves both RMW accumulation and readout fetches; state tells them apart.
  logic [RAM_LATENCY-1:0]   tag_vld_r;
  logic [BIN_WIDTH-1:0]     tag_bin_r [0:RAM_LATENCY-1];
  logic [CNT_IN_WIDTH-1:0]  tag_cnt_r [0:RAM_LATENCY-1];
  logic                     wr_vld_r;
  logic [BIN_WIDTH-1:0]     wr_bin_r;
  logic [COUNT_WIDTH-1:0]   wr_data_r;

  logic                     rd_valid_r, rd_last_r;
  logic [BIN_WIDTH-1:0]     rd_bin_r;
  logic [COUNT_WIDTH-1:0]   rd_data_r;

  logic                     accept_s, handshake_s, issue_s, tag_in_s, ram_we_s, tag_out_s;
  logic [BIN_WIDTH-1:0]     tag_bin_in_s, ram_waddr_s;
  logic [COUNT_WIDTH-1:0]   ram_wdata_s, ram_rdata_s, sum_s;
`ifdef HISTOGRAM_SATURATE_EN
  logic [COUNT_WIDTH:0]     wide_sum_s;
`endif

  histogram_ram #(
    .ADDR_WIDTH (BIN_WIDTH),
    .DATA_WIDTH (COUNT_WIDTH),
    .LATENCY    (RAM_LATENCY)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (tag_bin_in_s),
    .rdata (ram_rdata_s)
  );

  // Next-state and handshake/issue decode
  always_comb begin
    next_s      = state_r;
    accept_s    = in_vd && (state_r == ACCUM);
    handshake_s = rd_valid_r && rd_ready;
    issue_s     = (state_r == READOUT) && (!ro_pend_r || (handshake_s && !rd_last_r));
    case (state_r)
      CLEAR: begin
        if (clr_addr_r == LAST_BIN) next_s = ACCUM;
        else                        next_s = CLEAR;
      end
      ACCUM: begin
        if (cmd_clear || cmd_readout) next_s = DRAIN;
        else                          next_s = ACCUM;
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) next_s = (cmd_r == CMD_CLEAR) ? CLEAR : READOUT;
        else                           next_s = DRAIN;
      end
      READOUT: begin
        if (handshake_s && rd_last_r) next_s = ACCUM;
        else                          next_s = READOUT;
      end
      default: next_s = CLEAR;
    endcase
  end

  // RAM port steering: read address from input or readout counter, write from clear or RMW stage
  always_comb begin
    tag_in_s     = accept_s;
    tag_bin_in_s = in_bin;
    ram_we_s     = wr_vld_r;
    ram_waddr_s  = wr_bin_r;
    ram_wdata_s  = wr_data_r;
    tag_out_s    = tag_vld_r[RAM_LATENCY-1];
    if (state_r == READOUT) begin
      tag_in_s     = issue_s;
      tag_bin_in_s = ro_addr_r;
    end else begin
      tag_in_s     = accept_s;
      tag_bin_in_s = in_bin;
    end
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_r;
      ram_wdata_s = COUNT_ZERO;
    end else begin
      ram_we_s    = wr_vld_r;
      ram_waddr_s = wr_bin_r;
      ram_wdata_s = wr_data_r;
    end
  end

  // Read-modify-write adder
  always_comb begin
`ifdef HISTOGRAM_SATURATE_EN
    wide_sum_s = {1'b0, ram_rdata_s} + (COUNT_WIDTH+1)'(tag_cnt_r[RAM_LATENCY-1]);
    if (wide_sum_s[COUNT_WIDTH]) sum_s = COUNT_MAX;
    else                         sum_s = wide_sum_s[COUNT_WIDTH-1:0];
`else
    sum_s = ram_rdata_s + COUNT_WIDTH'(tag_cnt_r[RAM_LATENCY-1]);
`endif
  end

  // State register and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
      busy_r  <= 1'b1;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != ACCUM);
    end
  end

  // Address counters, latched command and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr_r  <= BIN_ZERO;
      ro_addr_r   <= BIN_ZERO;
      drain_cnt_r <= DRAIN_ZERO;
      cmd_r       <= CMD_NONE;
      ro_pend_r   <= 1'b0;
      drop_cnt_r  <= DROP_ZERO;
    end else begin
      clr_addr_r  <= (state_r == CLEAR) ? clr_addr_r + BIN_ONE : BIN_ZERO;
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + DRAIN_ONE : DRAIN_ZERO;
      if (state_r != READOUT) ro_addr_r <= BIN_ZERO;
      else if (issue_s)       ro_addr_r <= ro_addr_r + BIN_ONE;
      if (issue_s)          ro_pend_r <= 1'b1;
      else if (handshake_s) ro_pend_r <= 1'b0;
      // Clear takes priority when both commands arrive together
      if (state_r == ACCUM) begin
        if (cmd_clear)        cmd_r <= CMD_CLEAR;
        else if (cmd_readout) cmd_r <= CMD_READOUT;
        else                  cmd_r <= CMD_NONE;
      end
      if (in_vd && (state_r != ACCUM) && (drop_cnt_r != DROP_MAX)) drop_cnt_r <= drop_cnt_r + DROP_ONE;
    end
  end

  // Tag valid bits and write strobe; reset discards any pending RMW write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_r <= {RAM_LATENCY{1'b0}};
      wr_vld_r  <= 1'b0;
    end else begin
      tag_vld_r[0] <= tag_in_s;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
      end
      wr_vld_r <= tag_out_s && (state_r != READOUT);
    end
  end

  // Tag payload and RMW write-back data
  always_ff @(posedge clk) begin
    tag_bin_r[0] <= tag_bin_in_s;
    tag_cnt_r[0] <= in_cnt;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      tag_bin_r[i] <= tag_bin_r[i-1];
      tag_cnt_r[i] <= tag_cnt_r[i-1];
    end
    wr_bin_r  <= tag_bin_r[RAM_LATENCY-1];
    wr_data_r <= sum_s;
  end

  // Readout output register, held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_bin_r   <= BIN_ZERO;
      rd_data_r  <= COUNT_ZERO;
    end else if (tag_out_s && (state_r == READOUT)) begin
      rd_valid_r <= 1'b1;
      rd_last_r  <= (tag_bin_r[RAM_LATENCY-1] == LAST_BIN);
      rd_bin_r   <= tag_bin_r[RAM_LATENCY-1];
      rd_data_r  <= ram_rdata_s;
    end else if (handshake_s) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign drop_cnt = drop_cnt_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign rd_bin   = rd_bin_r;
  assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_histogram_ram_controller.sv
// Directed self-checking bench for histogram_ram_controller (16 bins, 8-bit counters, RAM latency 2).
module tb_histogram_ram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vd = 1'b0;
  logic [3:0]  in_bin = 4'd0;
  logic [3:0]  in_cnt = 4'd0;
  logic        cmd_clear = 1'b0;
  logic        cmd_readout = 1'b0;
  logic        rd_ready = 1'b0;
  logic        busy, rd_valid, rd_last;
  logic [15:0] drop_cnt;
  logic [3:0]  rd_bin;
  logic [7:0]  rd_data;

  int errors = 0;
  int checks = 0;
  int nb;
  int stall_moves;
  int rv_seen;
  bit stall_done;
  logic [3:0] rb_bin  [0:15];
  logic [7:0] rb_data [0:15];
  logic       rb_last [0:15];

  always #5 clk = ~clk;

  histogram_ram_controller #(
    .BIN_WIDTH(4), .CNT_IN_WIDTH(4), .COUNT_WIDTH(8), .RAM_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .in_vd(in_vd), .in_bin(in_bin), .in_cnt(in_cnt),
    .cmd_clear(cmd_clear), .cmd_readout(cmd_readout), .busy(busy), .drop_cnt(drop_cnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bin(rd_bin), .rd_data(rd_data), .rd_last(rd_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] b, input logic [3:0] c);
    in_vd = 1'b1; in_bin = b; in_cnt = c;
    tick();
    in_vd = 1'b0;
  endtask

  task automatic pulse_cmd(input logic clr, input logic ro);
    cmd_clear = clr; cmd_readout = ro;
    tick();
    cmd_clear = 1'b0; cmd_readout = 1'b0;
  endtask

  // Counts cycles until busy falls (bounded), noting any rd_valid seen meanwhile
  task automatic wait_idle(output int cycles);
    cycles = 0; rv_seen = 0;
    while (busy === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
      if (rd_valid === 1'b1) rv_seen++;
    end
  endtask

  // Issues a readout and records up to max_beats beats; optionally stalls on one bin
  task automatic run_readout(input int stall_bin, input int stall_len, input int max_beats, output bit to);
    bit done;
    logic [3:0] hb;
    logic [7:0] hd;
    nb = 0; stall_moves = 0; stall_done = 0; done = 0; to = 1;
    for (int i = 0; i < 16; i++) begin
      rb_bin[i] = 4'hx; rb_data[i] = 8'hxx; rb_last[i] = 1'bx;
    end
    rd_ready = 1'b1;
    pulse_cmd(1'b0, 1'b1);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (rd_valid === 1'b1) begin
        if (!stall_done && stall_bin >= 0 && int'(rd_bin) == stall_bin) begin
          stall_done = 1; hb = rd_bin; hd = rd_data; rd_ready = 1'b0;
          repeat (stall_len) begin
            tick();
            if (rd_valid !== 1'b1 || rd_bin !== hb || rd_data !== hd) stall_moves++;
          end
          rd_ready = 1'b1;
        end
        rb_bin[nb] = rd_bin; rb_data[nb] = rd_data; rb_last[nb] = rd_last;
        nb++;
        if (rd_last === 1'b1 || nb >= max_beats) begin
          done = 1; to = 0;
        end
      end
      if (!done) tick();
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit to;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b expected 1", busy); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
    checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL rst_rd_flags: got valid=%0b last=%0b expected 0 0", rd_valid, rd_last); end
    checks++; if (rd_bin !== 4'd0 || rd_data !== 8'd0) begin errors++; $display("FAIL rst_rd_regs: got bin=%0d data=%0d expected 0 0", rd_bin, rd_data); end
    rst = 1'b0;
    wait_idle(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL clear_len: got %0d cycles expected 16", cyc); end
    run_readout(-1, 0, 16, to);
    checks++; if (to || nb != 16) begin errors++; $display("FAIL reset_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== 8'd0 || rb_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL reset_beat%0d: got bin=%0d data=%0d last=%0b expected bin=%0d data=0 last=%0b", i, rb_bin[i], rb_data[i], rb_last[i], i, (i == 15));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_after_ro: got busy=%0b valid=%0b expected 0 0", busy, rd_valid); end
  endtask

  task automatic test_accum();
    bit to;
    logic [7:0] ex [0:15];
    for (int i = 0; i < 16; i++) ex[i] = 8'd0;
    ex[3] = 8'd3; ex[5] = 8'd4;
    send(4'd3, 4'd1);
    send(4'd5, 4'd4);
    tick(); tick();
    send(4'd3, 4'd2);
    run_readout(-1, 0, 16, to);
    checks++; if (to || nb != 16) begin errors++; $display("FAIL accum_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== ex[i] || rb_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL accum_beat%0d: got bin=%0d data=%0d last=%0b expected bin=%0d data=%0d", i, rb_bin[i], rb_data[i], rb_last[i], i, ex[i]);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    bit to;
    logic [7:0] ex [0:15];
    for (int i = 0; i < 16; i++) ex[i] = 8'd0;
    ex[3] = 8'd3; ex[5] = 8'd4;
    run_readout(7, 5, 16, to);
    checks++; if (stall_done != 1'b1 || stall_moves != 0) begin errors++; $display("FAIL stall_hold: got stalled=%0b moves=%0d expected 1 0", stall_done, stall_moves); end
    checks++; if (to || nb != 16) begin errors++; $display("FAIL stall_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== ex[i] || rb_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL stall_beat%0d: got bin=%0d data=%0d last=%0b expected bin=%0d data=%0d", i, rb_bin[i], rb_data[i], rb_last[i], i, ex[i]);
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    bit to;
    logic [7:0] ex [0:15];
    for (int i = 0; i < 16; i++) ex[i] = 8'd0;
    ex[3] = 8'd3; ex[5] = 8'd4;
`ifdef HISTOGRAM_SATURATE_EN
    ex[9] = 8'd255;
`else
    ex[9] = 8'd14;
`endif
    repeat (18) begin
      send(4'd9, 4'd15);
      tick(); tick(); tick();
    end
    run_readout(-1, 0, 16, to);
    checks++; if (to || nb != 16) begin errors++; $display("FAIL ovf_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== ex[i]) begin
        errors++;
        $display("FAIL ovf_beat%0d: got bin=%0d data=%0d expected bin=%0d data=%0d", i, rb_bin[i], rb_data[i], i, ex[i]);
      end
    end
    tick();
  endtask

  task automatic test_clear_wins();
    int cyc;
    int rv_early;
    bit to;
    rv_early = 0;
    pulse_cmd(1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL both_busy: got %0b expected 1", busy); end
    repeat (5) begin
      tick();
      if (rd_valid === 1'b1) rv_early++;
    end
    send(4'd2, 4'd1); tick();
    send(4'd4, 4'd1); tick();
    send(4'd6, 4'd1);
    wait_idle(cyc);
    checks++; if (rv_early + rv_seen != 0) begin errors++; $display("FAIL both_no_rd_valid: got %0d valid cycles expected 0", rv_early + rv_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_idle: got busy=%0b expected 0", busy); end
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_cnt: got %0d expected 3", drop_cnt); end
    run_readout(-1, 0, 16, to);
    checks++; if (to || nb != 16) begin errors++; $display("FAIL clr_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== 8'd0) begin
        errors++;
        $display("FAIL clr_beat%0d: got bin=%0d data=%0d expected bin=%0d data=0", i, rb_bin[i], rb_data[i], i);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_readout();
    int cyc;
    bit to;
    send(4'd1, 4'd5);
    run_readout(-1, 0, 6, to);
    checks++; if (to || nb != 6 || rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got beats=%0d valid=%0b expected 6 1", nb, rd_valid); end
    rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %0b expected 0", rd_valid); end
    checks++; if (busy !== 1'b1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_state: got busy=%0b drop=%0d expected 1 0", busy, drop_cnt); end
    tick();
    rst = 1'b0;
    wait_idle(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL mid_clear_len: got %0d cycles expected 16", cyc); end
    run_readout(-1, 0, 16, to);
    checks++; if (to || nb != 16) begin errors++; $display("FAIL mid_nbeats: got %0d timeout=%0b expected 16", nb, to); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_bin[i] !== 4'(i) || rb_data[i] !== 8'd0 || rb_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL mid_beat%0d: got bin=%0d data=%0d last=%0b expected bin=%0d data=0", i, rb_bin[i], rb_data[i], rb_last[i], i);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_accum();
    test_stall();
    test_overflow();
    test_clear_wins();
    test_reset_mid_readout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
